// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped down-counting timer for the PicoSoC iomem bus.
// A prescaler divides clk into ticks; each tick decrements COUNT, and a tick
// seen at COUNT==0 raises EXPIRED, which drives a level interrupt when IRQ_EN=1.
module iomem_timer #(
   parameter logic [7:0] ADDR_HI    = 8'h04,
   parameter int         PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        irq
);

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_PRESCALE = 3'd1;
   localparam logic [2:0] OFF_RELOAD   = 3'd2;
   localparam logic [2:0] OFF_COUNT    = 3'd3;
   localparam logic [2:0] OFF_STATUS   = 3'd4;

   logic                  ctrl_en;
   logic                  ctrl_auto;
   logic                  ctrl_irq_en;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] pre_cnt;
   logic [31:0]           reload;
   logic [31:0]           count;
   logic                  expired;

   logic                  sel;
   logic                  wr;
   logic [2:0]            off;
   logic                  tick;
   logic                  expire;
   logic [31:0]           count_tick;
   logic [PRESCALE_W-1:0] prescale_wr;
   logic [31:0]           prescale_ext;
   logic [31:0]           rd_val;
   logic                  unused_addr;

   // Byte-lane merge: strobed lanes take the bus data, the rest keep base.
   function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = base;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

   // A held valid is not re-selected while its ack is on the bus.
   assign sel    = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_HI);
   assign wr     = sel && (iomem_wstrb != 4'b0000);
   assign off    = iomem_addr[4:2];
   assign tick   = ctrl_en && (pre_cnt == prescale);
   assign expire = tick && (count == 32'd0);
   assign irq    = expired && ctrl_irq_en;

   assign unused_addr = &{1'b0, iomem_addr[23:5], iomem_addr[1:0]};

   // Count value after this cycle's tick, before any bus write overrides it.
   always_comb begin
      count_tick = count;
      if (tick) begin
         if (count != 32'd0)  count_tick = count - 32'd1;
         else if (ctrl_auto)  count_tick = reload;
      end
   end

   // Per-bit strobe merge for PRESCALE, whose width is not a byte multiple.
   always_comb begin
      prescale_wr = prescale;
      for (int i = 0; i < PRESCALE_W; i++) begin
         if (iomem_wstrb[i/8]) prescale_wr[i] = iomem_wdata[i];
      end
   end

   // Read mux; unimplemented bits and offsets read as zero.
   always_comb begin
      prescale_ext                   = '0;
      prescale_ext[PRESCALE_W-1:0]   = prescale;
      case (off)
         OFF_CTRL:     rd_val = {29'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
         OFF_PRESCALE: rd_val = prescale_ext;
         OFF_RELOAD:   rd_val = reload;
         OFF_COUNT:    rd_val = count;
         OFF_STATUS:   rd_val = {31'd0, expired};
         default:      rd_val = 32'd0;
      endcase
   end

   // One-cycle acknowledge; rdata captures the register addressed at select.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         iomem_ready <= 1'b0;
         iomem_rdata <= 32'd0;
      end else begin
         iomem_ready <= sel;
         if (sel) iomem_rdata <= rd_val;
      end
   end

   // Prescaler; holding at 0 while disabled also gives the clear on enable.
   always_ff @(posedge clk) begin
      if (!resetn)              pre_cnt <= '0;
      else if (!ctrl_en || tick) pre_cnt <= '0;
      else                      pre_cnt <= pre_cnt + 1'b1;
   end

   // Register file; bus writes are placed after timer updates so they win.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ctrl_en     <= 1'b0;
         ctrl_auto   <= 1'b0;
         ctrl_irq_en <= 1'b0;
         prescale    <= '0;
         reload      <= 32'd0;
         count       <= 32'd0;
         expired     <= 1'b0;
      end else begin
         if (expire && !ctrl_auto) ctrl_en <= 1'b0;
         if (wr && off == OFF_CTRL && iomem_wstrb[0]) begin
            ctrl_en     <= iomem_wdata[0];
            ctrl_auto   <= iomem_wdata[1];
            ctrl_irq_en <= iomem_wdata[2];
         end
         if (wr && off == OFF_PRESCALE) prescale <= prescale_wr;
         if (wr && off == OFF_RELOAD)   reload   <= merge_bytes(reload, iomem_wdata, iomem_wstrb);
         if (wr && off == OFF_COUNT)    count    <= merge_bytes(count_tick, iomem_wdata, iomem_wstrb);
         else                           count    <= count_tick;
         // Expiry set takes priority over a same-cycle write-1-to-clear.
         if (expire)
            expired <= 1'b1;
         else if (wr && off == OFF_STATUS && iomem_wstrb[0] && iomem_wdata[0])
            expired <= 1'b0;
      end
   end

endmodule

// File: doc/iomem_timer.md
Name: iomem_timer

Overview:
- Memory-mapped down-counting timer on the PicoSoC iomem bus. Sits directly downstream of the SoC's iomem port, alongside the board GPIO slave.
- Decodes its own address window and drives one level interrupt into a spare SoC irq input (irq_5).
- Gives firmware periodic ticks and timeouts without polling the cycle counter.

Parameters:
- ADDR_HI, 8'h04: value iomem_addr[31:24] must match for the block to respond.
- PRESCALE_W, 16: width of the PRESCALE register and the prescaler counter (1..32).

Ports:
- clk, input, 1: system clock.
- resetn, input, 1: synchronous, active-low reset.
- iomem_valid, input, 1: bus request.
- iomem_ready, output, 1: one-cycle acknowledge.
- iomem_wstrb, input, 4: byte write strobes; 0 means read.
- iomem_addr, input, 32: byte address.
- iomem_wdata, input, 32: write data.
- iomem_rdata, output, 32: read data, valid while iomem_ready=1.
- irq, output, 1: level interrupt, expired & IRQ_EN.

Behaviour:
- Reset is synchronous on clk, active-low on resetn. In reset: iomem_ready=0, iomem_rdata=0, CTRL=0, PRESCALE=0, RELOAD=0, COUNT=0, prescaler counter=0, EXPIRED=0, irq=0.
- Select condition: sel = iomem_valid && !iomem_ready && iomem_addr[31:24]==ADDR_HI.
- Handshake:
  - iomem_ready defaults to 0 every cycle.
  - On sel it goes to 1 the next cycle for exactly one cycle. Read and write latency is therefore 1 cycle.
  - No back-to-back ready; a held valid is acked every other cycle.
  - When ready=1, iomem_rdata holds the register addressed in the sel cycle. Otherwise iomem_rdata holds its last value.
  - Writes commit in the sel cycle.
  - Requests outside the window are ignored (ready stays 0).
- Register map (offset = iomem_addr[4:2]; per-byte wstrb honoured; unimplemented bits read 0 and ignore writes):
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN.
  - 0x04 PRESCALE: [PRESCALE_W-1:0].
  - 0x08 RELOAD: [31:0].
  - 0x0C COUNT: [31:0]. Read returns the live value; write loads it.
  - 0x10 STATUS: bit0 EXPIRED. Write 1 to clear.
  - Offsets 0x14..0x1C: read 0, writes ignored, still acked.
- Prescaler:
  - Runs only while EN=1.
  - tick = EN && pre_cnt==PRESCALE.
  - On tick, pre_cnt goes to 0; otherwise pre_cnt increments by 1.
  - A write that changes EN from 0 to 1 clears pre_cnt to 0.
  - While EN=0, pre_cnt holds at 0.
- Counter, on tick:
  - If COUNT != 0: COUNT decrements by 1 (no wrap).
  - If COUNT == 0: EXPIRED is set to 1. Then, if AUTO_RELOAD=1, COUNT loads RELOAD; otherwise EN is cleared and COUNT stays 0.
  - Period with auto-reload = (RELOAD+1)*(PRESCALE+1) cycles.
- Simultaneous events:
  - Bus write to COUNT in a tick cycle: the bus value wins and the decrement is dropped.
  - Bus write to CTRL in the cycle that one-shot expiry clears EN: the bus value wins.
  - STATUS W1C in the same cycle EXPIRED is set: set wins (EXPIRED=1).
  - A write to PRESCALE takes effect for the next compare. If the new PRESCALE is less than the current pre_cnt, the counter runs up to 2^PRESCALE_W-1, wraps to 0, then compares normally.
- irq: combinational AND of the EXPIRED and IRQ_EN registers. No pulse stretching. It deasserts the cycle after EXPIRED is cleared or IRQ_EN is written to 0.
- Reset mid-operation: every register returns to its reset value the next edge. A pending bus transaction is dropped with no ready.

Test Plan:
1. Reset, then read 0x04000000..0x04000010 → each ready exactly 1 cycle after valid, rdata=0, irq=0.
2. Write PRESCALE=3, RELOAD=4, COUNT=4, CTRL=0x7 → EXPIRED sets 20 cycles after the CTRL write. Then: irq=1; COUNT=4 the same cycle; repeats every 20 cycles.
3. One-shot: PRESCALE=0, COUNT=2, CTRL=0x5 → EXPIRED at cycle 3. After that, EN reads 0, COUNT stays 0, irq=1 until a write of 1 to STATUS, then irq=0 the next cycle.
4. wstrb=4'b0010 write of 0xAABBCCDD to RELOAD after RELOAD=0x11223344 → RELOAD reads 0x1122CC44.
5. W1C on STATUS in the exact cycle of a tick at COUNT=0 → EXPIRED remains 1. Write to COUNT=9 on a tick cycle → COUNT reads 9.
6. Address 0x03000000 with valid held → no ready. Address 0x04000018 → ready, rdata=0. resetn low for 1 cycle during a run → all registers 0, irq=0.
